// File: rtl/time_shared_multiplier.sv
// time_shared_multiplier: one unsigned WIDTHxWIDTH multiplier shared by two request channels
// Ports: clk_in, rst_n_in (sync, active-low); channel c in {0,1}: ac_in/bc_in operands,
//   validc_in/readyc_out request handshake; prod_out/id_out/res_valid_out with res_ready_in
//   form the result handshake. Define SHARED_MUL_RR_EN for round-robin arbitration,
//   otherwise channel 0 has fixed priority.
module time_shared_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [WIDTH-1:0]   a0_in,
  input  logic [WIDTH-1:0]   b0_in,
  input  logic               valid0_in,
  output logic               ready0_out,
  input  logic [WIDTH-1:0]   a1_in,
  input  logic [WIDTH-1:0]   b1_in,
  input  logic               valid1_in,
  output logic               ready1_out,
  output logic [2*WIDTH-1:0] prod_out,
  output logic               id_out,
  output logic               res_valid_out,
  input  logic               res_ready_in
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic id_q, id_d, gnt1, accept;
  logic [WIDTH-1:0] op_a, op_b;
`ifdef SHARED_MUL_RR_EN
  logic ptr_q;
  // on contention the channel that did not win last time is served
  assign gnt1 = valid1_in & (~valid0_in | ~ptr_q);
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) ptr_q <= 1'b1;
    else if (accept) ptr_q <= gnt1;
  end
`else
  assign gnt1 = valid1_in & ~valid0_in;
`endif
  // ready is masked during reset so nothing is accepted while rst_n_in is low
  assign ready0_out = rst_n_in & (state_q == IDLE) & valid0_in & ~gnt1;
  assign ready1_out = rst_n_in & (state_q == IDLE) & gnt1;
  assign accept = ready0_out | ready1_out;
  assign op_a = gnt1 ? a1_in : a0_in;
  assign op_b = gnt1 ? b1_in : b0_in;
  always_comb begin
    state_d = state_q;
    prod_d = prod_q;
    id_d = id_q;
    if (accept) begin
      state_d = HOLD;
      prod_d = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
      id_d = gnt1;
    end else if (state_q == HOLD && res_ready_in) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      prod_q <= '0;
      id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q <= prod_d;
      id_q <= id_d;
    end
  end
  assign prod_out = prod_q;
  assign id_out = id_q;
  assign res_valid_out = (state_q == HOLD);
endmodule

// File: tb/tb_time_shared_multiplier.sv
// tb_time_shared_multiplier: scoreboard bench for time_shared_multiplier
module tb_time_shared_multiplier;
  logic clk_in = 1'b0, rst_n_in = 1'b0;
  logic [7:0] a0_in = '0, b0_in = '0, a1_in = '0, b1_in = '0;
  logic valid0_in = 1'b0, valid1_in = 1'b0, res_ready_in = 1'b0;
  logic ready0_out, ready1_out, id_out, res_valid_out;
  logic [15:0] prod_out;
  int checks = 0, failures = 0;
  logic [16:0] sb[$];
  logic prev_v = 1'b0;

  time_shared_multiplier #(.WIDTH(8)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .a0_in(a0_in), .b0_in(b0_in), .valid0_in(valid0_in), .ready0_out(ready0_out),
    .a1_in(a1_in), .b1_in(b1_in), .valid1_in(valid1_in), .ready1_out(ready1_out),
    .prod_out(prod_out), .id_out(id_out), .res_valid_out(res_valid_out),
    .res_ready_in(res_ready_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic id, input logic [15:0] p);
    sb.push_back({id, p});
  endtask

  // a new result is any rising edge of res_valid_out; every result is separated by an idle cycle
  always @(negedge clk_in) begin
    if (res_valid_out && !prev_v) begin
      if (sb.size() == 0) chk("unexpected_result", {15'd0, id_out, prod_out}, 32'hFFFF_FFFF);
      else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("sb_prod", {16'd0, prod_out}, {16'd0, e[15:0]});
        chk("sb_id", {31'd0, id_out}, {31'd0, e[16]});
      end
    end
    prev_v = res_valid_out;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    @(negedge clk_in);
    chk("rst_valid", {31'd0, res_valid_out}, 0);
    chk("rst_prod", {16'd0, prod_out}, 0);
    chk("rst_id", {31'd0, id_out}, 0);
    chk("rst_ready", {30'd0, ready0_out, ready1_out}, 0);
    tick();
    rst_n_in = 1'b1;
    tick();
    // single request on channel 0
    valid0_in = 1; a0_in = 8'd12; b0_in = 8'd13; res_ready_in = 1;
    push(0, 16'd156);
    @(negedge clk_in);
    chk("t1_ready0", {31'd0, ready0_out}, 1);
    chk("t1_ready1", {31'd0, ready1_out}, 0);
    tick();
    valid0_in = 0;
    tick();
    // channel 1 maximum operands
    valid1_in = 1; a1_in = 8'hFF; b1_in = 8'hFF;
    push(1, 16'hFE01);
    @(negedge clk_in);
    chk("t2_ready1", {31'd0, ready1_out}, 1);
    tick();
    valid1_in = 0;
    tick();
    // withdrawn request leaves state untouched
    valid0_in = 1; a0_in = 8'd9; b0_in = 8'd9;
    @(negedge clk_in);
    chk("wd_ready0", {31'd0, ready0_out}, 1);
    #1 valid0_in = 0;
    tick();
    @(negedge clk_in);
    chk("wd_valid", {31'd0, res_valid_out}, 0);
    tick();
    // contention, results every 2 cycles
    valid0_in = 1; a0_in = 8'd2; b0_in = 8'd3;
    valid1_in = 1; a1_in = 8'd4; b1_in = 8'd5;
`ifdef SHARED_MUL_RR_EN
    push(0, 16'd6); push(1, 16'd20); push(0, 16'd6); push(1, 16'd20);
`else
    for (int i = 0; i < 4; i++) push(0, 16'd6);
`endif
    @(negedge clk_in);
    chk("ct_ready", {30'd0, ready0_out, ready1_out}, 2);
    for (int i = 0; i < 7; i++) tick();
    valid0_in = 0; valid1_in = 0;
    @(negedge clk_in);
    #2 chk("ct_rate_pending", sb.size(), 0);
    tick();
    tick();
    // held result is stable while downstream stalls
    valid0_in = 1; a0_in = 8'd3; b0_in = 8'd5; res_ready_in = 0;
    push(0, 16'd15);
    tick();
    valid0_in = 0; a0_in = 8'd7; b0_in = 8'd9;
    valid1_in = 1; a1_in = 8'd2; b1_in = 8'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("hold_prod", {16'd0, prod_out}, 15);
      chk("hold_ready", {30'd0, ready0_out, ready1_out}, 0);
      chk("hold_valid", {31'd0, res_valid_out}, 1);
      tick();
      a0_in = a0_in + 8'd1;
    end
    res_ready_in = 1;
    @(negedge clk_in);
    chk("hs_ready1_M", {31'd0, ready1_out}, 0);
    tick();
    push(1, 16'd4);
    @(negedge clk_in);
    chk("hs_ready1_M1", {31'd0, ready1_out}, 1);
    tick();
    valid1_in = 0;
    tick();
    // reset discards a held result
    valid0_in = 1; a0_in = 8'd3; b0_in = 8'd5; res_ready_in = 0;
    push(0, 16'd15);
    tick();
    valid0_in = 0;
    @(negedge clk_in);
    chk("rh_prod", {16'd0, prod_out}, 15);
    tick();
    rst_n_in = 0; valid0_in = 1; valid1_in = 1;
    tick();
    @(negedge clk_in);
    chk("rh_valid", {31'd0, res_valid_out}, 0);
    chk("rh_prod0", {16'd0, prod_out}, 0);
    chk("rh_ready", {30'd0, ready0_out, ready1_out}, 0);
    tick();
    rst_n_in = 1; a0_in = 8'd1; b0_in = 8'd1; a1_in = 8'd2; b1_in = 8'd2; res_ready_in = 1;
    push(0, 16'd1);
    @(negedge clk_in);
    chk("rr_first", {30'd0, ready0_out, ready1_out}, 2);
    tick();
    valid0_in = 0; valid1_in = 0;
    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
